// File: rtl/slt_arbiter_pkg.sv
// Shared types and constants for the two-requester set-less-than arbiter.
package slt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic CMP_SLT   = 1'b0;
    localparam logic CMP_SLTU  = 1'b1;
    localparam int   DEFAULT_N = 32;

endpackage

// File: rtl/slt_cmp.sv
// Combinational set-less-than comparator, signed or unsigned per uns.
module slt_cmp
    import slt_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         uns,
    output logic         lt
);

    logic mag_lt;

    assign mag_lt = (x < y);

    // With differing sign bits the negative operand (MSB set) is the smaller one.
    always_comb begin
        lt = mag_lt;
        if (uns == CMP_SLT && x[N-1] != y[N-1]) begin
            lt = x[N-1];
        end
    end

endmodule

// File: rtl/slt_arbiter.sv
// Round-robin arbiter sharing one SLT/SLTU comparator between two requesters.
//
//   state   | meaning
//   IDLE    | waiting for a request; grants one requester per cycle
//   COMPUTE | comparator evaluates the latched operands
//   RESP    | result held on rsp_* until rsp_ready
module slt_arbiter
    import slt_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         r0_valid,
    input  logic         r1_valid,
    output logic         r0_ready,
    output logic         r1_ready,
    input  logic [N-1:0] r0_x,
    input  logic [N-1:0] r0_y,
    input  logic [N-1:0] r1_x,
    input  logic [N-1:0] r1_y,
    input  logic         r0_uns,
    input  logic         r1_uns,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_result,
    output logic         rsp_id,
    output logic         busy
);

    state_t       state, state_nxt;
    logic         last_grant;
    logic         grant0, grant1;
    logic         accept;
    logic [N-1:0] op_x, op_y;
    logic         op_uns;
    logic         cmp_lt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_grant == 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        state_nxt = state;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        grant0    = r0_valid && (!r1_valid || last_grant);
        grant1    = r1_valid && !grant0;
        case (state)
            IDLE: begin
                if (reset_n) begin
                    r0_ready = grant0;
                    r1_ready = grant1;
                    if (grant0 || grant1) begin
                        state_nxt = COMPUTE;
                    end
                end
            end
            COMPUTE: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = r0_ready || r1_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_x       <= '0;
            op_y       <= '0;
            op_uns     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                op_x       <= r1_ready ? r1_x   : r0_x;
                op_y       <= r1_ready ? r1_y   : r0_y;
                op_uns     <= r1_ready ? r1_uns : r0_uns;
                rsp_id     <= r1_ready;
                last_grant <= r1_ready;
            end
            if (state == COMPUTE) begin
                rsp_result <= cmp_lt;
            end
        end
    end

    slt_cmp #(.N(N)) u_cmp (
        .x   (op_x),
        .y   (op_y),
        .uns (op_uns),
        .lt  (cmp_lt)
    );

endmodule

// File: tb/tb_slt_arbiter.sv
// Directed bench for slt_arbiter with a cycle-level reference model and literal checks.
module tb_slt_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_x, r0_y, r1_x, r1_y;
    logic        r0_uns, r1_uns;
    logic        rsp_valid, rsp_ready, rsp_result, rsp_id, busy;

    int n_checks = 0;
    int n_pass   = 0;

    bit       m_busy = 0;
    int       m_age  = 0;
    bit       m_last = 1;
    bit       m_res  = 0;
    bit       m_id   = 0;
    bit       pend_acc = 0;
    bit       pend_id  = 0;
    bit       pend_res = 0;
    bit       grant_log[$];
    logic [1:0] rsp_log[$];

    slt_arbiter #(.N(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_x(r0_x), .r0_y(r0_y), .r1_x(r1_x), .r1_y(r1_y),
        .r0_uns(r0_uns), .r1_uns(r1_uns),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic bit ref_lt(input logic [31:0] x, input logic [31:0] y, input bit uns);
        if (uns) return x < y;
        return $signed(x) < $signed(y);
    endfunction

    // Reference model: an op is in flight for compute + response cycles after acceptance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_age = 0; m_last = 1;
        end else if (!m_busy) begin
            if (pend_acc) begin
                m_busy = 1; m_age = 1; m_last = pend_id; m_id = pend_id; m_res = pend_res;
            end
        end else if (m_age >= 2) begin
            if (rsp_ready) m_busy = 0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        bit e0, e1, ev;
        e0 = reset_n && !m_busy && r0_valid && (!r1_valid || m_last);
        e1 = reset_n && !m_busy && r1_valid && !(r0_valid && (!r1_valid || m_last));
        ev = m_busy && (m_age >= 2);
        check("r0_ready", r0_ready, e0);
        check("r1_ready", r1_ready, e1);
        check("busy", busy, m_busy);
        check("rsp_valid", rsp_valid, ev);
        if (ev) begin
            check("rsp_result", rsp_result, m_res);
            check("rsp_id", rsp_id, m_id);
        end
        pend_acc = e0 || e1;
        pend_id  = e1;
        pend_res = e1 ? ref_lt(r1_x, r1_y, r1_uns) : ref_lt(r0_x, r0_y, r0_uns);
        if (r0_valid && r0_ready) grant_log.push_back(1'b0);
        else if (r1_valid && r1_ready) grant_log.push_back(1'b1);
        if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_result});
    end

    task automatic do_op(input bit req, input logic [31:0] x, input logic [31:0] y, input bit uns,
                         output bit got_id, output bit got_res);
        bit seen = 0;
        if (req) begin r1_x = x; r1_y = y; r1_uns = uns; r1_valid = 1; end
        else     begin r0_x = x; r0_y = y; r0_uns = uns; r0_valid = 1; end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req ? r1_ready : r0_ready;
        end
        if (!seen) timeout("grant");
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 0;
        @(negedge clk); check("lat_compute_valid", rsp_valid, 0);
        @(negedge clk); check("lat_resp_valid", rsp_valid, 1);
        got_id = rsp_id; got_res = rsp_result;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic drain();
        bit idle = 0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) timeout("drain");
        @(posedge clk); #1;
    endtask

    typedef struct { bit req; logic [31:0] x; logic [31:0] y; bit uns; bit res; } vec_t;
    vec_t vecs[$];

    initial begin
        bit gid, gres, seen;
        reset_n = 1; r0_valid = 0; r1_valid = 0; rsp_ready = 1;
        r0_x = 0; r0_y = 0; r1_x = 0; r1_y = 0; r0_uns = 0; r1_uns = 0;
        #1 reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_busy", busy, 0);
        reset_n = 1;
        @(posedge clk); #1;

        vecs.push_back('{0, 32'hFFFFFFFF, 32'h00000001, 0, 1});
        vecs.push_back('{1, 32'hFFFFFFFF, 32'h00000001, 1, 0});
        vecs.push_back('{0, 32'h80000000, 32'h80000000, 0, 0});
        vecs.push_back('{0, 32'h80000000, 32'h80000000, 1, 0});
        vecs.push_back('{1, 32'h80000000, 32'h7FFFFFFF, 0, 1});
        vecs.push_back('{1, 32'h80000000, 32'h7FFFFFFF, 1, 0});
        vecs.push_back('{0, 32'h00000005, 32'h00000005, 0, 0});
        vecs.push_back('{1, 32'h7FFFFFFF, 32'h80000000, 1, 1});
        foreach (vecs[k]) begin
            do_op(vecs[k].req, vecs[k].x, vecs[k].y, vecs[k].uns, gid, gres);
            check("vec_id", gid, vecs[k].req);
            check("vec_result", gres, vecs[k].res);
        end

        // Contention straight after reset: r0 first, then alternating.
        do_reset();
        grant_log.delete(); rsp_log.delete();
        r0_x = 3; r0_y = 7; r0_uns = 0;
        r1_x = 7; r1_y = 3; r1_uns = 1;
        r0_valid = 1; r1_valid = 1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            seen = (rsp_log.size() >= 4);
        end
        #1 r0_valid = 0; r1_valid = 0;
        if (!seen) timeout("contention");
        else begin
            check("cont_grant0", grant_log[0], 0);
            check("cont_grant1", grant_log[1], 1);
            check("cont_grant2", grant_log[2], 0);
            check("cont_grant3", grant_log[3], 1);
            check("cont_rsp0", rsp_log[0], 2'b01);
            check("cont_rsp1", rsp_log[1], 2'b10);
            check("cont_rsp2", rsp_log[2], 2'b01);
            check("cont_rsp3", rsp_log[3], 2'b10);
        end
        drain();

        // Backpressure with r0 waiting behind a held response.
        rsp_ready = 0;
        r1_x = 1; r1_y = 2; r1_uns = 0; r1_valid = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = r1_ready; end
        if (!seen) timeout("bp_grant");
        @(posedge clk); #1 r1_valid = 0;
        r0_x = 10; r0_y = 20; r0_uns = 1; r0_valid = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rsp_valid; end
        if (!seen) timeout("bp_rsp");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_result", rsp_result, 1);
            check("bp_r0_ready", r0_ready, 0);
            check("bp_r1_ready", r1_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1;
        check("bp_release_idle", busy, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = r0_ready; end
        if (!seen) timeout("bp_r0_grant");
        @(posedge clk); #1 r0_valid = 0;
        drain();

        // Reset during COMPUTE after an r0 grant; the pointer must return to favour r0.
        r0_x = 5; r0_y = 5; r0_uns = 0; r0_valid = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = r0_ready; end
        if (!seen) timeout("mid_grant");
        @(posedge clk); #1 r0_valid = 0;
        reset_n = 0;
        r0_x = 2; r0_y = 9; r1_x = 0; r1_y = 0;
        r0_valid = 1; r1_valid = 1;
        #2;
        check("mid_busy", busy, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_r0_ready", r0_ready, 0);
        check("mid_r1_ready", r1_ready, 0);
        grant_log.delete(); rsp_log.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); seen = (rsp_log.size() >= 1); end
        #1 r0_valid = 0; r1_valid = 0;
        if (!seen) timeout("mid_after");
        else begin
            check("mid_first_grant", grant_log[0], 0);
            check("mid_first_rsp", rsp_log[0], 2'b01);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slt_arbiter.md
SLT_ARBITER -- requirements
Module: slt_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports r0_valid / r1_valid  input  1  requester 0/1 has a compare pending.
REQ-005 SHALL have ports r0_ready / r1_ready  output  1  requester 0/1 operands accepted this cycle.
REQ-006 SHALL have ports r0_x, r0_y, r1_x, r1_y  input  N  operands.
REQ-007 SHALL have ports r0_uns / r1_uns  input  1  0 = SLT (signed), 1 = SLTU (unsigned).
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_result  output  1  1 when X < Y under selected signedness.
REQ-011 SHALL have port rsp_id  output  1  requester that issued the result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, COMPUTE, RESP.
REQ-014 IDLE: SHALL grant at most one requester per cycle; grant asserts that requester's ready combinationally with its valid, and the grantee's x, y, uns and id are latched on that edge; next state COMPUTE.
REQ-015 IDLE with no valid: SHALL hold, both ready low.
REQ-016 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it; the last-grant pointer updates only on an accepted request.
REQ-017 COMPUTE: SHALL evaluate the shared comparator on the latched operands, register the result into rsp_result, and move to RESP; exactly one cycle.
REQ-018 Signed compare: differing MSBs -> result = X[N-1]; equal MSBs -> unsigned magnitude compare of X and Y.
REQ-019 Unsigned compare: result = X < Y over all N bits.
REQ-020 RESP: SHALL hold rsp_valid high with rsp_result and rsp_id stable until rsp_ready is sampled high, then go to IDLE.
REQ-021 Both ready outputs SHALL be low in COMPUTE and RESP (no new acceptance until the response is consumed).
REQ-022 Latency: acceptance at edge t -> rsp_valid high from edge t+2; the minimum request-to-request period is 3 cycles when rsp_ready is held high.
REQ-023 Equal operands SHALL give result 0 in both modes.
REQ-024 A requester deasserting valid without being granted SHALL be a legal no-op.

Reset
REQ-025 On reset_n low, SHALL asynchronously force state IDLE, rsp_valid 0, rsp_result 0, rsp_id 0, busy 0, and a last-grant pointer of 1 (so requester 0 wins the first contention).
REQ-026 Reset during COMPUTE or RESP SHALL discard the in-flight operation with no response emitted.
REQ-027 ready outputs SHALL be 0 while reset_n is low.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, COMPUTE, RESP), the compare-mode constants (CMP_SLT = 0, CMP_SLTU = 1) and the default width 32.
REQ-029 The comparator SHALL be a separate combinational sub-module, slt_cmp (inputs X, Y, uns; output lt), with exactly one instance.

Verification
REQ-030 Signed: r0 sends x=0xFFFFFFFF, y=0x00000001, uns=0 -> rsp_result=1, rsp_id=0, rsp_valid two cycles after acceptance.
REQ-031 Unsigned: r1 sends the same operands with uns=1 -> rsp_result=0, rsp_id=1.
REQ-032 Contention: both valid continuously after reset, rsp_ready=1 -> grants in order r0, r1, r0, r1; each response matches its operands.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_result and rsp_id stay constant, both ready outputs stay 0; release -> IDLE the next cycle.
REQ-034 Reset mid-op: reset_n pulsed low in COMPUTE -> rsp_valid never asserts for that request, busy=0; the next contention grants r0.
REQ-035 Boundaries: x=y=0x80000000 in both modes -> 0; x=0x80000000, y=0x7FFFFFFF -> signed 1, unsigned 0.
